// File: rtl/pwm_pkg.sv
// Shared widths, scheduler states and the duty slew helper for pwm_update_sched.
package pwm_pkg;

  localparam int DUTY_W = 16;
  localparam int PRD_W  = 4;
  localparam int RES_W  = 3;

  localparam logic [DUTY_W-1:0] RAMP_STEP_DEF = 16'd256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RAMP = 2'd2
  } state_e;

  // Move cur toward tgt by at most step, landing exactly on tgt (no overshoot or wrap).
  function automatic logic [DUTY_W-1:0] ramp_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] step
  );
    logic [DUTY_W-1:0] res;
    if (tgt > cur) begin
      if ((tgt - cur) > step) res = cur + step;
      else                    res = tgt;
    end else begin
      if ((cur - tgt) > step) res = cur - step;
      else                    res = tgt;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_rr_arb.sv
// Round-robin arbiter: first unmasked request at or after rr_ptr, wrapping modulo NREQ.
module pwm_rr_arb #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   nxt_ptr
);

  logic [NREQ-1:0] cand_s;

  assign cand_s = req & ~mask;

  always_comb begin
    logic found;
    int   idx;
    grant   = {NREQ{1'b0}};
    nxt_ptr = rr_ptr;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && cand_s[idx]) begin
        grant[idx] = 1'b1;
        nxt_ptr    = PW'((idx + 1) % NREQ);
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/pwm_update_sched.sv
// Frame-synchronous PWM config update scheduler with round-robin requesters.
// Optional duty slew limiting is compiled in with PWM_RAMP_EN.
module pwm_update_sched
  import pwm_pkg::*;
#(
  parameter int                NREQ      = 4,
  parameter logic [DUTY_W-1:0] RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic               clk,
  input  logic               rsn,
  input  logic               enable,
  input  logic               frame_sync,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*16-1:0] req_data,
  input  logic [NREQ*4-1:0]  req_prd,
  input  logic [NREQ*3-1:0]  req_res,
  input  logic [NREQ-1:0]    req_pol,
  output logic [NREQ-1:0]    ack,
  output logic [15:0]        data_o,
  output logic [3:0]         prd_o,
  output logic [2:0]         res_o,
  output logic               pol_o,
  output logic               upd_pulse,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || RAMP_STEP == 16'd0) begin : g_bad_cfg
    $error("pwm_update_sched: NREQ must be 2..8 and RAMP_STEP nonzero");
  end

  logic [NREQ-1:0]   ack_q, ack_d;
  logic [DUTY_W-1:0] data_q, data_d;
  logic [PRD_W-1:0]  prd_q, prd_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              pol_q, pol_d;
  logic              upd_q, upd_d;
  logic              busy_q, busy_d;
  logic              pending_q, pending_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [DUTY_W-1:0] sh_data_q, sh_data_d;
  logic [PRD_W-1:0]  sh_prd_q, sh_prd_d;
  logic [RES_W-1:0]  sh_res_q, sh_res_d;
  logic              sh_pol_q, sh_pol_d;
  state_e            state_q, state_d;
`ifdef PWM_RAMP_EN
  logic [DUTY_W-1:0] tgt_q, tgt_d;
`endif

  logic [NREQ-1:0]   grant_s;
  logic [PW-1:0]     nxt_ptr_s;
  logic              grant_v_s;
  logic              commit_s;
  logic [DUTY_W-1:0] sel_data_s;
  logic [PRD_W-1:0]  sel_prd_s;
  logic [RES_W-1:0]  sel_res_s;
  logic              sel_pol_s;

  // The ack mask keeps a requester that is still holding req in its ack cycle from a second grant.
  pwm_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req     (req),
    .mask    (ack_q),
    .rr_ptr  (ptr_q),
    .grant   (grant_s),
    .nxt_ptr (nxt_ptr_s)
  );

  always_comb begin
    sel_data_s = {DUTY_W{1'b0}};
    sel_prd_s  = {PRD_W{1'b0}};
    sel_res_s  = {RES_W{1'b0}};
    sel_pol_s  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s[i]) begin
        sel_data_s = req_data[16*i +: 16];
        sel_prd_s  = req_prd[4*i +: 4];
        sel_res_s  = req_res[3*i +: 3];
        sel_pol_s  = req_pol[i];
      end else begin
        sel_pol_s = sel_pol_s;
      end
    end
  end

  always_comb begin
    ack_d     = {NREQ{1'b0}};
    upd_d     = 1'b0;
    data_d    = data_q;
    prd_d     = prd_q;
    res_d     = res_q;
    pol_d     = pol_q;
    pending_d = pending_q;
    ptr_d     = ptr_q;
    sh_data_d = sh_data_q;
    sh_prd_d  = sh_prd_q;
    sh_res_d  = sh_res_q;
    sh_pol_d  = sh_pol_q;
    state_d   = state_q;
`ifdef PWM_RAMP_EN
    tgt_d     = tgt_q;
`endif
    grant_v_s = enable && (grant_s != {NREQ{1'b0}});
    commit_s  = enable && frame_sync && pending_q;

    // Commit reads the shadow as registered, so a same-cycle grant lands for the next frame.
    if (commit_s) begin
      prd_d     = sh_prd_q;
      res_d     = sh_res_q;
      pol_d     = sh_pol_q;
      pending_d = 1'b0;
      upd_d     = 1'b1;
`ifdef PWM_RAMP_EN
      tgt_d     = sh_data_q;
      data_d    = ramp_toward(data_q, sh_data_q, RAMP_STEP);
`else
      data_d    = sh_data_q;
`endif
    end else begin
`ifdef PWM_RAMP_EN
      if (enable && frame_sync && (state_q == ST_RAMP)) begin
        data_d = ramp_toward(data_q, tgt_q, RAMP_STEP);
        upd_d  = 1'b1;
      end else begin
        data_d = data_q;
      end
`else
      data_d = data_q;
`endif
    end

    if (grant_v_s) begin
      sh_data_d = sel_data_s;
      sh_prd_d  = sel_prd_s;
      sh_res_d  = sel_res_s;
      sh_pol_d  = sel_pol_s;
      pending_d = 1'b1;
      ack_d     = grant_s;
      ptr_d     = nxt_ptr_s;
    end else begin
      ptr_d = ptr_q;
    end

`ifdef PWM_RAMP_EN
    if (data_d != tgt_d)  state_d = ST_RAMP;
    else if (pending_d)   state_d = ST_PEND;
    else                  state_d = ST_IDLE;
`else
    if (pending_d) state_d = ST_PEND;
    else           state_d = ST_IDLE;
`endif
    busy_d = (state_d != ST_IDLE);
  end

  // State, shadow and drive-facing registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rsn) begin
      ack_q     <= {NREQ{1'b0}};
      upd_q     <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= {DUTY_W{1'b0}};
      prd_q     <= {PRD_W{1'b0}};
      res_q     <= {RES_W{1'b0}};
      pol_q     <= 1'b0;
      pending_q <= 1'b0;
      ptr_q     <= {PW{1'b0}};
      sh_data_q <= {DUTY_W{1'b0}};
      sh_prd_q  <= {PRD_W{1'b0}};
      sh_res_q  <= {RES_W{1'b0}};
      sh_pol_q  <= 1'b0;
      state_q   <= ST_IDLE;
`ifdef PWM_RAMP_EN
      tgt_q     <= {DUTY_W{1'b0}};
`endif
    end else begin
      ack_q     <= ack_d;
      upd_q     <= upd_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      prd_q     <= prd_d;
      res_q     <= res_d;
      pol_q     <= pol_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      sh_data_q <= sh_data_d;
      sh_prd_q  <= sh_prd_d;
      sh_res_q  <= sh_res_d;
      sh_pol_q  <= sh_pol_d;
      state_q   <= state_d;
`ifdef PWM_RAMP_EN
      tgt_q     <= tgt_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign data_o    = data_q;
  assign prd_o     = prd_q;
  assign res_o     = res_q;
  assign pol_o     = pol_q;
  assign upd_pulse = upd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pwm_update_sched.sv
// Directed bench for pwm_update_sched with a behavioural model and commit scoreboard.
// Ramp-specific steps run only when PWM_RAMP_EN is defined.
module tb_pwm_update_sched;

  localparam int NREQ = 4;
  localparam logic [15:0] STEP = 16'h0100;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  p;
    logic [2:0]  r;
    logic        l;
  } cfg_t;

  logic               clk;
  logic               rsn;
  logic               enable;
  logic               frame_sync;
  logic [NREQ-1:0]    req;
  logic [NREQ*16-1:0] req_data;
  logic [NREQ*4-1:0]  req_prd;
  logic [NREQ*3-1:0]  req_res;
  logic [NREQ-1:0]    req_pol;
  logic [NREQ-1:0]    ack;
  logic [15:0]        data_o;
  logic [3:0]         prd_o;
  logic [2:0]         res_o;
  logic               pol_o;
  logic               upd_pulse;
  logic               busy;

  pwm_update_sched #(.NREQ(NREQ), .RAMP_STEP(STEP)) dut (
    .clk        (clk),
    .rsn        (rsn),
    .enable     (enable),
    .frame_sync (frame_sync),
    .req        (req),
    .req_data   (req_data),
    .req_prd    (req_prd),
    .req_res    (req_res),
    .req_pol    (req_pol),
    .ack        (ack),
    .data_o     (data_o),
    .prd_o      (prd_o),
    .res_o      (res_o),
    .pol_o      (pol_o),
    .upd_pulse  (upd_pulse),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  cfg_t        cfg [NREQ];
  cfg_t        m_sh;
  cfg_t        m_out;
  logic [15:0] m_tgt;
  logic        m_pend;
  logic [3:0]  m_ack;
  int          m_ptr;
  cfg_t        sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] step_to(input logic [15:0] cur, input logic [15:0] tgt);
`ifdef PWM_RAMP_EN
    if (tgt >= cur) return ((tgt - cur) > STEP) ? cur + STEP : tgt;
    else            return ((cur - tgt) > STEP) ? cur - STEP : tgt;
`else
    return tgt;
`endif
  endfunction

  task automatic set_cfg(input int i, input logic [15:0] d, input logic [3:0] p,
                         input logic [2:0] r, input logic l);
    cfg[i] = '{d: d, p: p, r: r, l: l};
    req_data[16*i +: 16] = d;
    req_prd[4*i +: 4]    = p;
    req_res[3*i +: 3]    = r;
    req_pol[i]           = l;
  endtask

  // One clock: drive, predict, then compare ack/pulse/busy/duty and drain the scoreboard.
  task automatic step(input logic fs, input logic [3:0] r);
    logic [3:0] cand;
    logic [3:0] e_ack;
    logic       pulse;
    int         np;
    int         gi;
    cfg_t       o;
    frame_sync = fs;
    req        = r;
    e_ack = 4'b0000;
    np    = m_ptr;
    gi    = -1;
    pulse = 1'b0;
    if (enable) begin
      cand = r & ~m_ack;
      for (int k = 0; k < NREQ; k++) begin
        if (gi < 0 && cand[(m_ptr + k) % NREQ]) begin
          gi = (m_ptr + k) % NREQ;
          e_ack[gi] = 1'b1;
          np = (gi + 1) % NREQ;
        end
      end
    end
    if (enable && fs && m_pend) begin
      m_out.p = m_sh.p;
      m_out.r = m_sh.r;
      m_out.l = m_sh.l;
      m_tgt   = m_sh.d;
      m_out.d = step_to(m_out.d, m_tgt);
      m_pend  = 1'b0;
      pulse   = 1'b1;
    end else if (enable && fs && (m_out.d != m_tgt)) begin
      m_out.d = step_to(m_out.d, m_tgt);
      pulse   = 1'b1;
    end
    if (gi >= 0) begin
      m_sh   = cfg[gi];
      m_pend = 1'b1;
    end
    m_ack = e_ack;
    m_ptr = np;
    if (pulse) sb.push_back(m_out);
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
    chk("ack", {28'd0, ack}, {28'd0, e_ack});
    chk("upd_pulse", {31'd0, upd_pulse}, {31'd0, pulse});
    chk("busy", {31'd0, busy}, {31'd0, (m_pend || (m_out.d != m_tgt))});
    chk("data_o", {16'd0, data_o}, {16'd0, m_out.d});
    if (upd_pulse === 1'b1 && sb.size() > 0) begin
      o = sb.pop_front();
      chk("sb_data", {16'd0, data_o}, {16'd0, o.d});
      chk("sb_prd", {28'd0, prd_o}, {28'd0, o.p});
      chk("sb_res", {29'd0, res_o}, {29'd0, o.r});
      chk("sb_pol", {31'd0, pol_o}, {31'd0, o.l});
    end
  endtask

  task automatic do_reset();
    rsn        = 1'b0;
    req        = 4'b0000;
    frame_sync = 1'b0;
    @(posedge clk);
    #1;
    rsn    = 1'b1;
    m_out  = '0;
    m_sh   = '0;
    m_tgt  = 16'h0000;
    m_pend = 1'b0;
    m_ack  = 4'b0000;
    m_ptr  = 0;
    sb.delete();
    chk("rst_data", {16'd0, data_o}, 32'd0);
    chk("rst_prd", {28'd0, prd_o}, 32'd0);
    chk("rst_res", {29'd0, res_o}, 32'd0);
    chk("rst_pol", {31'd0, pol_o}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_upd", {31'd0, upd_pulse}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rsn = 1'b0; enable = 1'b1; frame_sync = 1'b0; req = 4'b0000;
    req_data = '0; req_prd = '0; req_res = '0; req_pol = '0;
    for (int i = 0; i < NREQ; i++) set_cfg(i, 16'h0000, 4'd0, 3'd0, 1'b0);
    @(posedge clk);
    do_reset();

    // Single request, committed on the following frame boundary.
    set_cfg(1, 16'h4000, 4'd3, 3'd2, 1'b1);
    step(1'b0, 4'b0010);
    chk("single_ack", {28'd0, ack}, 32'h2);
    step(1'b0, 4'b0000);
    chk("single_hold", {16'd0, data_o}, 32'd0);
    step(1'b1, 4'b0000);
    chk("single_prd", {28'd0, prd_o}, 32'd3);
    chk("single_res", {29'd0, res_o}, 32'd2);
    chk("single_pol", {31'd0, pol_o}, 32'd1);
`ifndef PWM_RAMP_EN
    chk("single_data", {16'd0, data_o}, 32'h4000);
`endif
    step(1'b0, 4'b0000);

    // Fairness: all requesters re-raise after their ack; order 0,1,2,3 then 0.
    do_reset();
    set_cfg(0, 16'h1111, 4'd1, 3'd1, 1'b0);
    set_cfg(1, 16'h2222, 4'd2, 3'd2, 1'b1);
    set_cfg(2, 16'h3333, 4'd3, 3'd3, 1'b0);
    set_cfg(3, 16'h4444, 4'd4, 3'd4, 1'b1);
    step(1'b0, 4'b1111);
    chk("rr_0", {28'd0, ack}, 32'h1);
    step(1'b0, 4'b1110);
    chk("rr_1", {28'd0, ack}, 32'h2);
    step(1'b0, 4'b1101);
    chk("rr_2", {28'd0, ack}, 32'h4);
    step(1'b0, 4'b1011);
    chk("rr_3", {28'd0, ack}, 32'h8);
    step(1'b1, 4'b0111);
    chk("rr_wrap", {28'd0, ack}, 32'h1);
    chk("rr_commit_prd", {28'd0, prd_o}, 32'd4);

    // Overwrite and grant/commit collision.
    set_cfg(2, 16'h1000, 4'd5, 3'd5, 1'b1);
    set_cfg(3, 16'h2000, 4'd6, 3'd6, 1'b0);
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0100);
    step(1'b1, 4'b1000);
    chk("coll_prd", {28'd0, prd_o}, 32'd5);
    chk("coll_busy", {31'd0, busy}, 32'd1);
`ifndef PWM_RAMP_EN
    chk("coll_data", {16'd0, data_o}, 32'h1000);
`endif
    step(1'b1, 4'b0000);
    chk("ovr_prd", {28'd0, prd_o}, 32'd6);
`ifndef PWM_RAMP_EN
    chk("ovr_data", {16'd0, data_o}, 32'h2000);
`endif

    // Enable gating: no grants and frame_sync ignored while disabled.
    set_cfg(0, 16'hFFFF, 4'd15, 3'd7, 1'b1);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b1, 4'b0001);
    chk("en_prd_hold", {28'd0, prd_o}, 32'd6);
    enable = 1'b1;
    step(1'b0, 4'b0001);
    chk("en_ack", {28'd0, ack}, 32'h1);
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0000);
    chk("en_prd", {28'd0, prd_o}, 32'd15);
`ifndef PWM_RAMP_EN
    chk("en_data_max", {16'd0, data_o}, 32'hFFFF);
`endif

`ifdef PWM_RAMP_EN
    // Slew-limited ramp up to 0x0280 and back down to 0.
    do_reset();
    set_cfg(0, 16'h0280, 4'd1, 3'd1, 1'b0);
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0000);
    chk("ramp_up1", {16'd0, data_o}, 32'h0100);
    step(1'b1, 4'b0000);
    chk("ramp_up2", {16'd0, data_o}, 32'h0200);
    step(1'b1, 4'b0000);
    chk("ramp_up3", {16'd0, data_o}, 32'h0280);
    chk("ramp_idle", {31'd0, busy}, 32'd0);
    step(1'b1, 4'b0000);
    set_cfg(1, 16'h0000, 4'd2, 3'd2, 1'b1);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0000);
    chk("ramp_dn1", {16'd0, data_o}, 32'h0180);
    step(1'b1, 4'b0000);
    chk("ramp_dn2", {16'd0, data_o}, 32'h0080);
    step(1'b1, 4'b0000);
    chk("ramp_dn3", {16'd0, data_o}, 32'h0000);
    // Reset in the middle of a ramp.
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0000);
    chk("ramp_mid", {31'd0, busy}, 32'd1);
    do_reset();
    step(1'b1, 4'b0000);
`endif

    // Reset while an update is pending discards it.
    set_cfg(2, 16'h5A5A, 4'd9, 3'd3, 1'b1);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    chk("pend_busy", {31'd0, busy}, 32'd1);
    do_reset();
    step(1'b1, 4'b0000);
    chk("pend_discard", {16'd0, data_o}, 32'd0);
    step(1'b1, 4'b0000);

    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_update_sched.md
# pwm_update_sched

Update scheduler placed in front of the PWM drive: it shares one PWM channel's configuration among several requesters and applies changes only at PWM frame boundaries, so the drive never sees a torn duty/period/resolution/polarity combination mid-frame. Round-robin arbitration grants one requester per cycle into a shadow register. The shadow is committed to the drive-facing outputs on the next frame-sync pulse. An optional slew limiter ramps the duty over several frames.

## Interface
- NREQ, 4, number of requesters (2..8)
- RAMP_STEP, 16'd256, max duty change per frame when ramping is compiled in (nonzero)
- clk  in  1  system clock
- rsn  in  1  synchronous reset, active-low
- enable  in  1  scheduler enable; 0 suppresses grants and commits
- frame_sync  in  1  one-cycle pulse marking a PWM frame boundary
- req  in  NREQ  per-requester update request, level, held until acked
- req_data  in  NREQ*16  duty per requester, slice i = [16i+15:16i]
- req_prd  in  NREQ*4  period code per requester
- req_res  in  NREQ*3  resolution code per requester
- req_pol  in  NREQ  polarity per requester
- ack  out  NREQ  one-cycle grant acknowledge, one-hot or zero
- data_o  out  16  duty to drive
- prd_o  out  4  period code to drive
- res_o  out  3  resolution code to drive
- pol_o  out  1  polarity to drive
- upd_pulse  out  1  one-cycle pulse when the outputs change
- busy  out  1  pending update or ramp in progress

## Operation
- States: IDLE (no pending update), PEND (shadow valid, waiting for frame), RAMP (config committed, duty still converging; only with ramp compiled in).
- Arbitration: among req & ~ack, pick the first set bit at or after rr_ptr, wrapping modulo NREQ. On a grant:
  - copy that requester's slices into the shadow
  - set pending
  - pulse ack[i]
  - rr_ptr <= i+1 mod NREQ
- Requester drops req in the cycle it sees ack. The ack mask prevents a double grant.
- Overwrite: a grant while pending replaces the shadow (last writer wins). The state stays PEND.
- Commit: frame_sync && enable && pending:
  - prd_o/res_o/pol_o <= shadow
  - data_o <= shadow duty, or the ramp step (see Configuration)
  - clear pending
  - pulse upd_pulse
- Simultaneous grant and commit: the commit uses the shadow as it was before that cycle. The new grant lands in the shadow and leaves pending set.
- enable=0:
  - no acks
  - frame_sync ignored
  - shadow, pending, outputs and rr_ptr hold
- busy = pending | (state==RAMP).
- Reset (rsn=0 at a clk edge):
  - data_o=0, prd_o=0, res_o=0, pol_o=0
  - ack=0, upd_pulse=0, busy=0
  - pending=0, rr_ptr=0, state IDLE
- Reset mid-ramp or mid-pending discards the update.

## Timing
- ack[i] rises the cycle after req[i] is first sampled high and i wins the arbitration.
- Outputs update on the clk edge following the frame_sync cycle. upd_pulse is coincident with that update.
- Worst-case grant latency for a held request: NREQ cycles while enable=1.
- Duty arithmetic is unsigned 16-bit. The ramp step saturates at the target with no overshoot or wrap.

## Configuration
- PWM_RAMP_EN defined:
  - on commit, config fields apply immediately
  - data_o moves toward the target by at most RAMP_STEP per frame_sync, one upd_pulse per step
  - state RAMP until data_o equals the target, then IDLE
  - a new grant during RAMP replaces the target; the next frame commits the new config and continues ramping from the current data_o
- PWM_RAMP_EN undefined:
  - data_o takes the shadow duty at commit
  - RAMP state and the RAMP_STEP logic are absent

## Structure
- Shared package pwm_pkg:
  - width constants (duty 16, PRD 4, RES 3)
  - state enum {IDLE, PEND, RAMP}
  - default RAMP_STEP
- One sub-module, pwm_rr_arb: NREQ-wide round-robin arbiter (req, mask, rr_ptr in; one-hot grant and next pointer out).
- Shadow, commit and ramp logic live in the top.

## Test plan
- Single request: req[1] with data=0x4000, prd=3, res=2, pol=1 → ack[1] one cycle later; busy=1; data_o stays 0 until the next frame_sync; then data_o=0x4000, prd_o=3, res_o=2, pol_o=1, upd_pulse for 1 cycle.
- Fairness: req=4'b1111 held, re-raised after each ack, rr_ptr=0 → acks in order 0,1,2,3,0. Shadow holds requester 3's data at the frame_sync after the fourth ack.
- Overwrite and collision:
  - grant A (0x1000), then grant B (0x2000) in the same cycle as frame_sync → data_o=0x1000 and pending stays set
  - next frame_sync → data_o=0x2000
- Enable gating: enable=0 with req[0] high and 3 frame_syncs → no ack, outputs unchanged. Set enable=1 → ack[0] next cycle.
- Ramp (PWM_RAMP_EN, RAMP_STEP=0x100):
  - data_o 0 → target 0x0280: after successive frame_syncs data_o = 0x100, 0x200, 0x280, then IDLE, busy=0
  - repeat downward from 0x0280 → target 0: data_o = 0x180, 0x080, 0
- Reset mid-operation: rsn low for 1 cycle while in RAMP or PEND → all outputs 0, busy=0, and the next frame_sync produces no upd_pulse.
